ahb_bus_matrix_input_stage: RTL and testbench



---
 rtl/ahb_bm_pkg.sv | 35 +++
 rtl/ahb_bus_matrix_hold_reg.sv | 25 ++
 rtl/ahb_bus_matrix_input_stage.sv | 104 ++++++++++
 tb/tb_ahb_bus_matrix_input_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bm_pkg.sv
// Shared AHB bus-matrix definitions: transfer/response encodings, widths and
// the address-phase bundle that travels from the input stage to the output stages.
package ahb_bm_pkg;

    localparam int AW = 32;
    localparam int UW = 32;
    localparam int MW = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    // Full address/control phase of one transfer, as arbitrated on by output stages
    typedef struct packed {
        logic          sel;
        logic [AW-1:0] addr;
        logic [UW-1:0] auser;
        logic [1:0]    trans;
        logic          write;
        logic [2:0]    size;
        logic [2:0]    burst;
        logic [3:0]    prot;
        logic [MW-1:0] master;
        logic          mastlock;
    } ahb_addr_t;

endpackage

// File: rtl/ahb_bus_matrix_hold_reg.sv
// Address-phase capture bank: samples the master's address/control on every
// HREADYS=1 cycle and replays it while a transfer is pending.
module ahb_bus_matrix_hold_reg
    import ahb_bm_pkg::*;
(
    input  logic      HCLK,
    input  logic      HRESETn,
    input  logic      capture,
    input  logic      pend_tran,
    input  ahb_addr_t live,
    output ahb_addr_t bundle
);

    ahb_addr_t held;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            held <= '0;
        else if (capture)
            held <= live;
    end

    assign bundle = pend_tran ? held : live;

endmodule

// File: rtl/ahb_bus_matrix_input_stage.sv
// Master-facing input stage of the AHB bus matrix: holds an address phase the
// addressed output stage could not take, stalls the master, and returns data-phase status.
module ahb_bus_matrix_input_stage
    import ahb_bm_pkg::*;
(
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSELS,
    input  logic [AW-1:0] HADDRS,
    input  logic [UW-1:0] HAUSERS,
    input  logic [1:0]    HTRANSS,
    input  logic          HWRITES,
    input  logic [2:0]    HSIZES,
    input  logic [2:0]    HBURSTS,
    input  logic [3:0]    HPROTS,
    input  logic [MW-1:0] HMASTERS,
    input  logic          HMASTLOCKS,
    input  logic          HREADYS,
    input  logic          active_ip,
    input  logic          addr_ready_ip,
    input  logic          data_ready_ip,
    input  logic [1:0]    data_resp_ip,
    output logic          HREADYOUTS,
    output logic [1:0]    HRESPS,
    output logic          sel_ip,
    output logic [AW-1:0] addr_ip,
    output logic [UW-1:0] auser_ip,
    output logic [1:0]    trans_ip,
    output logic          write_ip,
    output logic [2:0]    size_ip,
    output logic [2:0]    burst_ip,
    output logic [3:0]    prot_ip,
    output logic [MW-1:0] master_ip,
    output logic          mastlock_ip,
    output logic          held_tran_ip
);

    logic      pend_tran, pend_nxt;
    logic      dphase, dphase_nxt;
    logic      tran_valid, accept;
    ahb_addr_t live, bundle;

    assign live = '{sel: HSELS, addr: HADDRS, auser: HAUSERS, trans: HTRANSS,
                    write: HWRITES, size: HSIZES, burst: HBURSTS, prot: HPROTS,
                    master: HMASTERS, mastlock: HMASTLOCKS};

    // HTRANS[1] covers NONSEQ and SEQ; IDLE and BUSY never request
    assign tran_valid   = HSELS & HREADYS & HTRANSS[1];
    assign held_tran_ip = pend_tran | tran_valid;
    assign accept       = held_tran_ip & active_ip & addr_ready_ip;

    ahb_bus_matrix_hold_reg u_hold (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .capture   (HREADYS),
        .pend_tran (pend_tran),
        .live      (live),
        .bundle    (bundle)
    );

    assign sel_ip      = bundle.sel;
    assign addr_ip     = bundle.addr;
    assign auser_ip    = bundle.auser;
    assign trans_ip    = bundle.trans;
    assign write_ip    = bundle.write;
    assign size_ip     = bundle.size;
    assign burst_ip    = bundle.burst;
    assign prot_ip     = bundle.prot;
    assign master_ip   = bundle.master;
    assign mastlock_ip = bundle.mastlock;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_tran <= 1'b0;
            dphase    <= 1'b0;
        end else begin
            pend_tran <= pend_nxt;
            dphase    <= dphase_nxt;
        end
    end

    // A transfer granted in its issuing cycle goes straight to the data phase
    always_comb begin
        pend_nxt   = pend_tran;
        dphase_nxt = dphase;
        HREADYOUTS = 1'b1;
        HRESPS     = HRESP_OKAY;
        if (accept)
            pend_nxt = 1'b0;
        else if (tran_valid)
            pend_nxt = 1'b1;
        if (accept)
            dphase_nxt = 1'b1;
        else if (data_ready_ip)
            dphase_nxt = 1'b0;
        if (dphase) begin
            HREADYOUTS = data_ready_ip;
            HRESPS     = data_resp_ip;
        end else if (pend_tran) begin
            HREADYOUTS = 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_bus_matrix_input_stage.sv
// Scenario bench for the AHB bus-matrix input stage; a scoreboard tracks every
// issued transfer and checks that output stages see each one exactly once, in order.
module tb_ahb_bus_matrix_input_stage;
    import ahb_bm_pkg::*;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSELS, HWRITES, HMASTLOCKS, HREADYS;
    logic [AW-1:0] HADDRS;
    logic [UW-1:0] HAUSERS;
    logic [1:0]    HTRANSS;
    logic [2:0]    HSIZES, HBURSTS;
    logic [3:0]    HPROTS;
    logic [MW-1:0] HMASTERS;
    logic          active_ip, addr_ready_ip, data_ready_ip;
    logic [1:0]    data_resp_ip;
    logic          HREADYOUTS;
    logic [1:0]    HRESPS;
    logic          sel_ip, write_ip, mastlock_ip, held_tran_ip;
    logic [AW-1:0] addr_ip;
    logic [UW-1:0] auser_ip;
    logic [1:0]    trans_ip;
    logic [2:0]    size_ip, burst_ip;
    logic [3:0]    prot_ip;
    logic [MW-1:0] master_ip;

    always #5 HCLK = ~HCLK;

    ahb_bus_matrix_input_stage dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
        .HAUSERS(HAUSERS), .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES),
        .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTERS(HMASTERS),
        .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .active_ip(active_ip),
        .addr_ready_ip(addr_ready_ip), .data_ready_ip(data_ready_ip),
        .data_resp_ip(data_resp_ip), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .sel_ip(sel_ip), .addr_ip(addr_ip), .auser_ip(auser_ip), .trans_ip(trans_ip),
        .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip), .prot_ip(prot_ip),
        .master_ip(master_ip), .mastlock_ip(mastlock_ip), .held_tran_ip(held_tran_ip)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic          write;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Every accept seen by the output stages must match the oldest issued transfer
    always @(negedge HCLK) begin
        if (HRESETn === 1'b1 && held_tran_ip === 1'b1 && active_ip && addr_ready_ip) begin
            exp_t e;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL accept_unexpected got addr=%h trans=%0d", addr_ip, trans_ip);
            end else begin
                e = sb.pop_front();
                if ({addr_ip, trans_ip, write_ip} !== {e.addr, e.trans, e.write}) begin
                    fails++;
                    $display("FAIL accept_order got %h/%0d/%b exp %h/%0d/%b",
                             addr_ip, trans_ip, write_ip, e.addr, e.trans, e.write);
                end
            end
        end
    end

    task automatic next_cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] tr, input logic [AW-1:0] a,
                         input logic w, input logic hrdy, input logic act);
        HSELS     = sel;
        HTRANSS   = tr;
        HADDRS    = a;
        HWRITES   = w;
        HREADYS   = hrdy;
        active_ip = act;
        if (sel && hrdy && tr[1]) sb.push_back('{a, tr, w});
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        HSELS = 0; HADDRS = 32'hA5A5_0000; HAUSERS = 32'h1234_5678; HTRANSS = HTRANS_IDLE;
        HWRITES = 0; HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3; HMASTERS = 4'h5;
        HMASTLOCKS = 0; HREADYS = 1; active_ip = 0; addr_ready_ip = 1;
        data_ready_ip = 1; data_resp_ip = 2'b00;
        #22;
        tests++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL rst_hreadyout got %b exp 1", HREADYOUTS); end
        tests++; if (HRESPS !== 2'b00) begin fails++; $display("FAIL rst_hresp got %b exp 00", HRESPS); end
        tests++; if (held_tran_ip !== 1'b0) begin fails++; $display("FAIL rst_held got %b exp 0", held_tran_ip); end
        tests++; if (addr_ip !== 32'hA5A5_0000 || master_ip !== 4'h5) begin
            fails++; $display("FAIL rst_live got %h/%h exp a5a50000/5", addr_ip, master_ip); end
        next_cyc();
        HRESETn = 1'b1;
        next_cyc();
    endtask

    task automatic test_zero_wait();
        next_cyc();
        drive(1, HTRANS_NONSEQ, 32'h0000_1000, 0, 1, 1);
        #1;
        tests++; if (HREADYOUTS !== 1'b1 || held_tran_ip !== 1'b1) begin
            fails++; $display("FAIL zw_issue got rdy=%b held=%b exp 1/1", HREADYOUTS, held_tran_ip); end
        next_cyc();
        drive(1, HTRANS_IDLE, 32'h0000_1004, 0, 0, 0);
        data_ready_ip = 0;
        #1;
        tests++; if (HREADYOUTS !== 1'b0 || held_tran_ip !== 1'b0) begin
            fails++; $display("FAIL zw_dphase_wait got rdy=%b held=%b exp 0/0", HREADYOUTS, held_tran_ip); end
        next_cyc();
        data_ready_ip = 1; HREADYS = 1;
        #1;
        tests++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL zw_dphase_done got %b exp 1", HREADYOUTS); end
        next_cyc();
    endtask

    task automatic test_held_write();
        next_cyc();
        HMASTERS = 4'hA;
        drive(1, HTRANS_NONSEQ, 32'h2000_0010, 1, 1, 0);
        #1;
        tests++; if (HREADYOUTS !== 1'b1 || held_tran_ip !== 1'b1 || addr_ip !== 32'h2000_0010) begin
            fails++; $display("FAIL hw_issue got rdy=%b held=%b addr=%h", HREADYOUTS, held_tran_ip, addr_ip); end
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            HMASTERS = 4'h1;
            drive(1, HTRANS_IDLE, 32'hDEAD_0000, 0, 0, (i == 2));
            #1;
            tests++;
            if (addr_ip !== 32'h2000_0010 || held_tran_ip !== 1'b1 || write_ip !== 1'b1 ||
                master_ip !== 4'hA || HREADYOUTS !== 1'b0) begin
                fails++;
                $display("FAIL hw_hold%0d got addr=%h held=%b w=%b m=%h rdy=%b exp 20000010/1/1/a/0",
                         i, addr_ip, held_tran_ip, write_ip, master_ip, HREADYOUTS);
            end
        end
        next_cyc();
        active_ip = 0; data_ready_ip = 0;
        #1;
        tests++; if (HREADYOUTS !== 1'b0) begin fails++; $display("FAIL hw_dphase_wait got %b exp 0", HREADYOUTS); end
        next_cyc();
        data_ready_ip = 1; HREADYS = 1;
        #1;
        tests++; if (HREADYOUTS !== 1'b1 || held_tran_ip !== 1'b0) begin
            fails++; $display("FAIL hw_done got rdy=%b held=%b exp 1/0", HREADYOUTS, held_tran_ip); end
        next_cyc();
    endtask

    task automatic test_burst();
        next_cyc();
        HBURSTS = 3'b011;
        drive(1, HTRANS_NONSEQ, 32'h3000_0000, 0, 1, 1);
        #1;
        tests++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL b1_rdy got %b exp 1", HREADYOUTS); end
        next_cyc();
        drive(1, HTRANS_SEQ, 32'h3000_0004, 0, 1, 0);
        #1;
        tests++; if (HREADYOUTS !== 1'b1 || held_tran_ip !== 1'b1) begin
            fails++; $display("FAIL b2_issue got rdy=%b held=%b exp 1/1", HREADYOUTS, held_tran_ip); end
        next_cyc();
        drive(1, HTRANS_SEQ, 32'h3000_0008, 0, 0, 1);
        #1;
        tests++; if (addr_ip !== 32'h3000_0004 || trans_ip !== HTRANS_SEQ || HREADYOUTS !== 1'b0) begin
            fails++; $display("FAIL b2_replay got addr=%h tr=%0d rdy=%b exp 30000004/3/0", addr_ip, trans_ip, HREADYOUTS); end
        next_cyc();
        drive(1, HTRANS_SEQ, 32'h3000_0008, 0, 1, 1);
        #1;
        tests++; if (HREADYOUTS !== 1'b1 || addr_ip !== 32'h3000_0008) begin
            fails++; $display("FAIL b3 got rdy=%b addr=%h exp 1/30000008", HREADYOUTS, addr_ip); end
        next_cyc();
        drive(1, HTRANS_SEQ, 32'h3000_000C, 0, 1, 1);
        #1;
        tests++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL b4 got %b exp 1", HREADYOUTS); end
        next_cyc();
        drive(0, HTRANS_IDLE, 32'h0, 0, 1, 0);
        HBURSTS = 3'b000;
        #1;
        tests++; if (HREADYOUTS !== 1'b1 || held_tran_ip !== 1'b0) begin
            fails++; $display("FAIL burst_end got rdy=%b held=%b exp 1/0", HREADYOUTS, held_tran_ip); end
        next_cyc();
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL burst_sb_left got %0d exp 0", sb.size()); end
    endtask

    task automatic test_error();
        next_cyc();
        drive(1, HTRANS_NONSEQ, 32'h4000_0000, 1, 1, 1);
        next_cyc();
        drive(1, HTRANS_IDLE, 32'h4000_0004, 0, 0, 0);
        data_ready_ip = 0; data_resp_ip = HRESP_ERROR;
        #1;
        tests++; if (HRESPS !== 2'b01 || HREADYOUTS !== 1'b0 || held_tran_ip !== 1'b0) begin
            fails++; $display("FAIL err_cyc1 got resp=%b rdy=%b held=%b exp 01/0/0", HRESPS, HREADYOUTS, held_tran_ip); end
        next_cyc();
        data_ready_ip = 1; HREADYS = 1;
        #1;
        tests++; if (HRESPS !== 2'b01 || HREADYOUTS !== 1'b1 || held_tran_ip !== 1'b0) begin
            fails++; $display("FAIL err_cyc2 got resp=%b rdy=%b held=%b exp 01/1/0", HRESPS, HREADYOUTS, held_tran_ip); end
        next_cyc();
        data_resp_ip = HRESP_OKAY;
        #1;
        tests++; if (HRESPS !== 2'b00 || HREADYOUTS !== 1'b1) begin
            fails++; $display("FAIL err_after got resp=%b rdy=%b exp 00/1", HRESPS, HREADYOUTS); end
        next_cyc();
    endtask

    task automatic test_reset_mid();
        next_cyc();
        drive(1, HTRANS_NONSEQ, 32'h5000_0000, 0, 1, 0);
        next_cyc();
        drive(1, HTRANS_IDLE, 32'h0, 0, 0, 0);
        #1;
        tests++; if (HREADYOUTS !== 1'b0 || held_tran_ip !== 1'b1) begin
            fails++; $display("FAIL rm_pending got rdy=%b held=%b exp 0/1", HREADYOUTS, held_tran_ip); end
        #1;
        HRESETn = 1'b0;
        sb.delete();
        #1;
        tests++; if (HREADYOUTS !== 1'b1 || held_tran_ip !== 1'b0) begin
            fails++; $display("FAIL rm_async got rdy=%b held=%b exp 1/0", HREADYOUTS, held_tran_ip); end
        next_cyc();
        next_cyc();
        HRESETn = 1'b1;
        drive(1, HTRANS_NONSEQ, 32'h5100_0000, 0, 1, 1);
        #1;
        tests++; if (HREADYOUTS !== 1'b1 || held_tran_ip !== 1'b1 || addr_ip !== 32'h5100_0000) begin
            fails++; $display("FAIL rm_fresh got rdy=%b held=%b addr=%h", HREADYOUTS, held_tran_ip, addr_ip); end
        next_cyc();
        drive(0, HTRANS_IDLE, 32'h0, 0, 1, 0);
        #1;
        tests++; if (HREADYOUTS !== 1'b1 || held_tran_ip !== 1'b0) begin
            fails++; $display("FAIL rm_fresh_done got rdy=%b held=%b exp 1/0", HREADYOUTS, held_tran_ip); end
        next_cyc();
    endtask

    task automatic test_idle_busy();
        next_cyc();
        drive(1, HTRANS_BUSY, 32'h6000_0100, 0, 1, 1);
        #1;
        tests++; if (held_tran_ip !== 1'b0 || HREADYOUTS !== 1'b1) begin
            fails++; $display("FAIL busy got held=%b rdy=%b exp 0/1", held_tran_ip, HREADYOUTS); end
        next_cyc();
        drive(1, HTRANS_IDLE, 32'h6000_0200, 0, 1, 1);
        #1;
        tests++; if (held_tran_ip !== 1'b0 || HREADYOUTS !== 1'b1) begin
            fails++; $display("FAIL idle got held=%b rdy=%b exp 0/1", held_tran_ip, HREADYOUTS); end
        next_cyc();
        drive(1, HTRANS_NONSEQ, 32'h6000_0000, 1, 1, 0);
        next_cyc();
        drive(1, HTRANS_BUSY, 32'h6000_0004, 0, 0, 0);
        #1;
        tests++; if (held_tran_ip !== 1'b1 || HREADYOUTS !== 1'b0 || addr_ip !== 32'h6000_0000 ||
                     trans_ip !== HTRANS_NONSEQ) begin
            fails++; $display("FAIL busy_pend got held=%b rdy=%b addr=%h tr=%0d", held_tran_ip, HREADYOUTS, addr_ip, trans_ip); end
        next_cyc();
        active_ip = 1;
        #1;
        tests++; if (HREADYOUTS !== 1'b0) begin fails++; $display("FAIL busy_grant got %b exp 0", HREADYOUTS); end
        next_cyc();
        drive(0, HTRANS_IDLE, 32'h0, 0, 1, 0);
        #1;
        tests++; if (HREADYOUTS !== 1'b1) begin fails++; $display("FAIL busy_done got %b exp 1", HREADYOUTS); end
        next_cyc();
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL final_sb_left got %0d exp 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_held_write();
        test_burst();
        test_error();
        test_reset_mid();
        test_idle_busy();
        repeat (2) @(posedge HCLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
